brq_dmem_responder: RTL and testbench
=====================================

Name: brq_dmem_responder

Overview:
Data-memory slave for the Buraq RV32IM core. It receives the load/store requests the core issues (read/write enables, byte address, store data, access-size code) and returns load data. It sits between the core's data-memory port and on-chip block RAM. It handles byte/half/word lanes, load sign/zero extension, optional wait states and misalignment detection.

Parameters:
DataWidth, 32, data bus width; only 32 is supported.
AddrWidth, 15, byte-address width; array depth is 2^(AddrWidth-2) words.
WaitStates, 0, number of extra stall cycles per access (0..15).

Ports:
brq_clk  input  1  clock; all state updates on rising edge.
brq_rst  input  1  synchronous active-high reset.
Data_mem_read_en  input  1  load request.
Data_mem_write_en  input  1  store request.
Data_mem_address  input  AddrWidth  byte address.
Data_mem_dataIn  input  DataWidth  store data, right-aligned.
ldst_byte_en  input  3  access code (RV32 func3): 000 B, 001 H, 010 W, 100 BU, 101 HU.
Data_mem_dataOut  output  DataWidth  load result, extended to 32 bits.
dmem_ready  output  1  high when a new request can be accepted.
dmem_misalign_err  output  1  sticky error flag.

Behaviour:
- Reset (brq_rst=1 at an edge): state to IDLE; Data_mem_dataOut=0; dmem_ready=1; dmem_misalign_err=0; wait counter=0. Array contents are not cleared. Reset during WAIT discards the pending access, and no write occurs.
- Word index = address[AddrWidth-1:2]; lane = address[1:0].
- Request = read_en | write_en, sampled only in IDLE. Inputs in other states are ignored.
- If read_en and write_en are both high, the write wins. No read is performed and dataOut is unchanged.
- FSM states are IDLE and WAIT.
  - IDLE with a request and WaitStates=0: the access completes at the same edge. A write updates the array; a read registers dataOut, valid the next cycle (1-cycle latency). State stays IDLE and dmem_ready stays 1.
  - IDLE with a request and WaitStates=N>0: latch address, data, code and enables; counter=N; go to WAIT; dmem_ready=0.
  - WAIT: the counter decrements each cycle. At the edge where counter==1, perform the latched access, return to IDLE and set dmem_ready=1. Total latency from request edge to dataOut valid is N+1 cycles.
- Stores use byte write enables, and only the addressed lanes change:
  - B writes dataIn[7:0] to the lane.
  - H writes dataIn[15:0] to lanes {addr[1],0}+1:0.
  - W writes all 4 lanes.
- Loads:
  - B sign-extends the selected byte; BU zero-extends it.
  - H sign-extends the selected half; HU zero-extends it.
  - W returns the whole word.
- Misaligned access (H/HU with addr[0]=1, W with addr[1:0]!=0) or illegal code (011, 110, 111):
  - No array write occurs.
  - A read sets dataOut=0.
  - dmem_misalign_err is set and held until reset.
  - Timing (including wait states) is unchanged.
- dataOut holds its last value between reads, including across writes to the same address.
- Read-after-write to the same word on consecutive requests returns the new data (no stale read).

Test Plan:
- Reset, then check outputs: dataOut=0, ready=1, err=0 -> all confirmed the cycle after reset.
- SW 0xDEADBEEF @0x10, then LW @0x10 -> dataOut=0xDEADBEEF one cycle after the read request.
- SB 0x80 @0x21, then LB @0x21 -> 0xFFFFFF80; LBU @0x21 -> 0x00000080; LW @0x20 -> only byte 1 changed.
- SH 0x8001 @0x32, then LH -> 0xFFFF8001; LHU -> 0x00008001. Then LH @0x33 -> dataOut=0, err=1, memory unchanged.
- WaitStates=3: LW @0x10 -> ready low for 3 cycles, dataOut valid 4 cycles after the request. A request asserted while ready=0 is ignored.
- Simultaneous read_en and write_en SW 0x12345678 @0x40 -> a later LW returns 0x12345678 and dataOut is unchanged in the cycle after the collision. Reset asserted mid-WAIT on a store -> the target word keeps its old value.

Source files
------------

// File: rtl/brq_dmem_responder.sv
// Data-memory slave for the Buraq RV32IM core: byte/half/word lanes, load extension,
// optional wait states and a sticky misalignment flag in front of an on-chip word array.
module brq_dmem_responder #(
  parameter int DataWidth  = 32,
  parameter int AddrWidth  = 15,
  parameter int WaitStates = 0
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic                 Data_mem_read_en,
  input  logic                 Data_mem_write_en,
  input  logic [AddrWidth-1:0] Data_mem_address,
  input  logic [DataWidth-1:0] Data_mem_dataIn,
  input  logic [2:0]           ldst_byte_en,
  output logic [DataWidth-1:0] Data_mem_dataOut,
  output logic                 dmem_ready,
  output logic                 dmem_misalign_err
);

  localparam int         Depth    = 2 ** (AddrWidth - 2);
  localparam logic [3:0] WaitInit = 4'(WaitStates);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [AddrWidth-1:0]   lat_addr;
  logic [DataWidth-1:0]   lat_data;
  logic [2:0]             lat_code;
  logic                   lat_re, lat_we;

  logic [DataWidth-1:0]   mem [Depth];

  logic                   req, fire, bad, do_write, do_read;
  logic [AddrWidth-1:0]   acc_addr;
  logic [DataWidth-1:0]   acc_data;
  logic [2:0]             acc_code;
  logic                   acc_re, acc_we;
  logic [AddrWidth-3:0]   idx;
  logic [1:0]             lane;
  logic [3:0]             be;
  logic [DataWidth-1:0]   wdata, word, load_val;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;

  assign req = Data_mem_read_en | Data_mem_write_en;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    acc_addr = Data_mem_address;
    acc_data = Data_mem_dataIn;
    acc_code = ldst_byte_en;
    acc_re   = Data_mem_read_en;
    acc_we   = Data_mem_write_en;
    fire     = req && (WaitStates == 0);
    if (state == S_WAIT) begin
      acc_addr = lat_addr;
      acc_data = lat_data;
      acc_code = lat_code;
      acc_re   = lat_re;
      acc_we   = lat_we;
      fire     = (cnt == 4'd1);
    end
  end

  assign idx  = acc_addr[AddrWidth-1:2];
  assign lane = acc_addr[1:0];

  always_comb begin
    case (acc_code)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = lane[0];
      3'b010:         bad = (lane != 2'b00);
      default:        bad = 1'b1;
    endcase
  end

  // Store data is replicated across lanes; the byte enables pick which lanes land.
  always_comb begin
    case (acc_code[1:0])
      2'b00: begin
        be    = 4'b0001 << lane;
        wdata = {4{acc_data[7:0]}};
      end
      2'b01: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wdata = {2{acc_data[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = acc_data;
      end
    endcase
  end

  assign word     = mem[idx];
  assign byte_sel = word[{lane, 3'b000} +: 8];
  assign half_sel = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (acc_code)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'd0, half_sel};
      3'b010:  load_val = word;
      default: load_val = '0;
    endcase
    if (bad) load_val = '0;
  end

  // Write wins over read; a reset edge cancels whatever access would complete on it.
  assign do_write = fire && acc_we && !bad && !brq_rst;
  assign do_read  = fire && acc_re && !acc_we;

  // NOTE: the array is deliberately left out of reset so it maps onto block RAM.
  always_ff @(posedge brq_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (do_write && be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      state             <= S_IDLE;
      cnt               <= 4'd0;
      Data_mem_dataOut  <= '0;
      dmem_ready        <= 1'b1;
      dmem_misalign_err <= 1'b0;
    end else begin
      if (fire && bad) dmem_misalign_err <= 1'b1;
      if (do_read)     Data_mem_dataOut  <= load_val;
      case (state)
        S_IDLE: begin
          if (req && (WaitStates != 0)) begin
            lat_addr   <= Data_mem_address;
            lat_data   <= Data_mem_dataIn;
            lat_code   <= ldst_byte_en;
            lat_re     <= Data_mem_read_en;
            lat_we     <= Data_mem_write_en;
            cnt        <= WaitInit;
            state      <= S_WAIT;
            dmem_ready <= 1'b0;
          end
        end
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state      <= S_IDLE;
            dmem_ready <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brq_dmem_responder.sv
// Self-checking bench: a zero-wait instance driven from a vector table and a
// three-wait-state instance driven by hand-written timing sequences.
module tb_brq_dmem_responder;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, re0, we0, rst3, re3, we3;
  logic [14:0] addr0, addr3;
  logic [31:0] din0, din3, dout0, dout3;
  logic [2:0]  code0, code3;
  logic        ready0, err0, ready3, err3;

  brq_dmem_responder #(.DataWidth(32), .AddrWidth(15), .WaitStates(0)) dut0 (
    .brq_clk(clk), .brq_rst(rst0), .Data_mem_read_en(re0), .Data_mem_write_en(we0),
    .Data_mem_address(addr0), .Data_mem_dataIn(din0), .ldst_byte_en(code0),
    .Data_mem_dataOut(dout0), .dmem_ready(ready0), .dmem_misalign_err(err0));

  brq_dmem_responder #(.DataWidth(32), .AddrWidth(15), .WaitStates(3)) dut3 (
    .brq_clk(clk), .brq_rst(rst3), .Data_mem_read_en(re3), .Data_mem_write_en(we3),
    .Data_mem_address(addr3), .Data_mem_dataIn(din3), .ldst_byte_en(code3),
    .Data_mem_dataOut(dout3), .dmem_ready(ready3), .dmem_misalign_err(err3));

  typedef struct {
    logic        re, we;
    logic [14:0] addr;
    logic [31:0] data;
    logic [2:0]  code;
    logic [31:0] exp_dout;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] dout;
    logic        err;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs[NV];
  exp_t sb_q[$];
  exp_t e;
  int   checks = 0, failures = 0, n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic re, input logic we, input logic [14:0] a,
                              input logic [31:0] d, input logic [2:0] c,
                              input logic [31:0] xd, input logic xe);
    vec_t v;
    v = '{re: re, we: we, addr: a, data: d, code: c, exp_dout: xd, exp_err: xe};
    return v;
  endfunction

  task automatic drive0(input logic re, input logic we, input logic [14:0] a,
                        input logic [31:0] d, input logic [2:0] c);
    re0 = re; we0 = we; addr0 = a; din0 = d; code0 = c;
  endtask

  task automatic drive3(input logic re, input logic we, input logic [14:0] a,
                        input logic [31:0] d, input logic [2:0] c);
    re3 = re; we3 = we; addr3 = a; din3 = d; code3 = c;
  endtask

  // Issue one request to the wait-state instance and wait (bounded) for ready.
  task automatic access3(input logic re, input logic we, input logic [14:0] a,
                         input logic [31:0] d, input logic [2:0] c, output int cycles);
    drive3(re, we, a, d, c);
    @(negedge clk);
    drive3(1'b0, 1'b0, '0, '0, W);
    cycles = 1;
    while (!ready3 && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  initial begin
    vecs[0]  = mk(0, 1, 15'h20, 32'h11223344, W,  32'h00000000, 0);
    vecs[1]  = mk(0, 1, 15'h21, 32'h00000080, B,  32'h00000000, 0);
    vecs[2]  = mk(1, 0, 15'h20, 32'h0,        W,  32'h11228044, 0);
    vecs[3]  = mk(1, 0, 15'h21, 32'h0,        B,  32'hFFFFFF80, 0);
    vecs[4]  = mk(1, 0, 15'h21, 32'h0,        BU, 32'h00000080, 0);
    vecs[5]  = mk(1, 0, 15'h23, 32'h0,        B,  32'h00000011, 0);
    vecs[6]  = mk(0, 1, 15'h10, 32'hDEADBEEF, W,  32'h00000011, 0);
    vecs[7]  = mk(1, 0, 15'h10, 32'h0,        W,  32'hDEADBEEF, 0);
    vecs[8]  = mk(0, 1, 15'h30, 32'hAAAABBBB, W,  32'hDEADBEEF, 0);
    vecs[9]  = mk(0, 1, 15'h32, 32'h00008001, H,  32'hDEADBEEF, 0);
    vecs[10] = mk(1, 0, 15'h32, 32'h0,        H,  32'hFFFF8001, 0);
    vecs[11] = mk(1, 0, 15'h32, 32'h0,        HU, 32'h00008001, 0);
    vecs[12] = mk(1, 0, 15'h30, 32'h0,        H,  32'hFFFFBBBB, 0);
    vecs[13] = mk(1, 0, 15'h33, 32'h0,        BU, 32'h00000080, 0);
    vecs[14] = mk(1, 1, 15'h40, 32'h12345678, W,  32'h00000080, 0);
    vecs[15] = mk(1, 0, 15'h40, 32'h0,        W,  32'h12345678, 0);
    vecs[16] = mk(1, 0, 15'h33, 32'h0,        H,  32'h00000000, 1);
    vecs[17] = mk(1, 0, 15'h30, 32'h0,        W,  32'h8001BBBB, 1);
    vecs[18] = mk(0, 1, 15'h31, 32'h0000FFFF, H,  32'h8001BBBB, 1);
    vecs[19] = mk(1, 0, 15'h30, 32'h0,        W,  32'h8001BBBB, 1);
    vecs[20] = mk(1, 0, 15'h02, 32'h0,        W,  32'h00000000, 1);
    vecs[21] = mk(1, 0, 15'h30, 32'h0,        W,  32'h8001BBBB, 1);
    vecs[22] = mk(1, 0, 15'h30, 32'h0,        3'b110, 32'h00000000, 1);

    rst0 = 1'b1; rst3 = 1'b1;
    drive0(0, 0, '0, '0, W);
    drive3(0, 0, '0, '0, W);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst0 = 1'b0; rst3 = 1'b0;
    check("rst0_dout", dout0, 32'h0);
    check("rst0_ready", 32'(ready0), 32'h1);
    check("rst0_err", 32'(err0), 32'h0);
    check("rst3_dout", dout3, 32'h0);
    check("rst3_ready", 32'(ready3), 32'h1);
    check("rst3_err", 32'(err3), 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive0(vecs[i].re, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].code);
      sb_q.push_back('{dout: vecs[i].exp_dout, err: vecs[i].exp_err});
      @(negedge clk);
      e = sb_q.pop_front();
      check($sformatf("vec%0d_dout", i), dout0, e.dout);
      check($sformatf("vec%0d_err", i), 32'(err0), 32'(e.err));
      check($sformatf("vec%0d_ready", i), 32'(ready0), 32'h1);
    end
    drive0(0, 0, '0, '0, W);

    // Reset clears the sticky flag but not the array.
    rst0 = 1'b1;
    @(negedge clk);
    rst0 = 1'b0;
    check("rst0b_err", 32'(err0), 32'h0);
    check("rst0b_dout", dout0, 32'h0);
    drive0(1, 0, 15'h30, '0, W);
    @(negedge clk);
    drive0(0, 0, '0, '0, W);
    check("mem_kept_after_rst", dout0, 32'h8001BBBB);

    // Wait-state store: three cycles of ready low.
    access3(0, 1, 15'h10, 32'hCAFEF00D, W, n);
    check("ws_store_latency", 32'(n), 32'h4);

    // Wait-state load with a request injected while busy.
    drive3(1, 0, 15'h10, '0, W);
    sb_q.push_back('{dout: 32'hCAFEF00D, err: 1'b0});
    @(negedge clk);
    drive3(0, 1, 15'h10, 32'h0, W);
    check("ws_c1_ready", 32'(ready3), 32'h0);
    check("ws_c1_dout", dout3, 32'h0);
    @(negedge clk);
    drive3(0, 0, '0, '0, W);
    check("ws_c2_ready", 32'(ready3), 32'h0);
    @(negedge clk);
    check("ws_c3_ready", 32'(ready3), 32'h0);
    check("ws_c3_dout", dout3, 32'h0);
    @(negedge clk);
    check("ws_c4_ready", 32'(ready3), 32'h1);
    e = sb_q.pop_front();
    check("ws_load_dout", dout3, e.dout);

    access3(1, 0, 15'h10, '0, W, n);
    check("ws_ignored_req_latency", 32'(n), 32'h4);
    check("ws_ignored_req_dout", dout3, 32'hCAFEF00D);

    // Reset in the middle of a waited store discards it.
    drive3(0, 1, 15'h10, 32'h55555555, W);
    @(negedge clk);
    drive3(0, 0, '0, '0, W);
    @(negedge clk);
    rst3 = 1'b1;
    @(negedge clk);
    rst3 = 1'b0;
    check("ws_rst_ready", 32'(ready3), 32'h1);
    sb_q.push_back('{dout: 32'hCAFEF00D, err: 1'b0});
    access3(1, 0, 15'h10, '0, W, n);
    e = sb_q.pop_front();
    check("ws_rst_no_write", dout3, e.dout);
    check("ws_rst_latency", 32'(n), 32'h4);

    // Misaligned word load through the wait path.
    access3(1, 0, 15'h12, '0, W, n);
    check("ws_mis_latency", 32'(n), 32'h4);
    check("ws_mis_dout", dout3, 32'h0);
    check("ws_mis_err", 32'(err3), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
